// File: rtl/tt_sine_pkg.sv
// Shared definitions for the sine generator output path: sample width,
// PWM midscale and the signed-sample to offset-binary duty conversion.
package tt_sine_pkg;

    localparam int SAMPLE_WL = 16;
    localparam int PWM_WL_DEF = 8;
    localparam int PWM_MID = 2 ** (PWM_WL_DEF - 1);

    // Flip the sign bit to get offset binary, then keep the top pwm_wl bits
    // right-aligned. Lower bits are truncated, never rounded.
    function automatic logic [SAMPLE_WL-1:0] to_offset_bin(
        input logic [SAMPLE_WL-1:0] sample,
        input int                   pwm_wl
    );
        logic [SAMPLE_WL-1:0] flipped;
        flipped = sample ^ {1'b1, {(SAMPLE_WL-1){1'b0}}};
        return flipped >> (SAMPLE_WL - pwm_wl);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: emits a one-cycle tick every (div+1) clk cycles while
// enabled. Reusable for any timed output that needs a slow tick.
module pwm_prescaler #(
    parameter int DIV_WL = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_WL-1:0] div,
    output logic              tick
);

    logic [DIV_WL-1:0] pre_cnt;

    // div is compared live, so a new value applies at the next compare; if it
    // drops below pre_cnt the counter runs up through its maximum and wraps.
    assign tick = en & (pre_cnt == div);

    // Prescale counter: cleared while disabled, restarts after every tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (!en) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + DIV_WL'(1);
        end
    end

endmodule

// File: rtl/pwm_dac_out.sv
// PWM DAC output stage: takes signed samples over valid/ready into a
// one-deep buffer, swaps the active duty only at period boundaries and
// drives a registered 1-bit PWM stream. Missed samples raise a sticky flag.
module pwm_dac_out
    import tt_sine_pkg::*;
#(
    parameter int WL     = SAMPLE_WL,
    parameter int PWM_WL = 8,
    parameter int DIV_WL = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_WL-1:0] div,
    input  logic              s_valid,
    input  logic [WL-1:0]     s_data,
    output logic              s_ready,
    input  logic              clr_underrun,
    output logic              pwm_out,
    output logic              period_start,
    output logic              underrun
);

    localparam logic [PWM_WL-1:0] DUTY_MID = PWM_WL'(PWM_MID);

    logic              tick;
    logic              boundary;
    logic              accept;
    logic [PWM_WL-1:0] duty;
    logic [PWM_WL-1:0] cnt;
    logic [PWM_WL-1:0] act_duty;
    logic [PWM_WL-1:0] nxt_duty;
    logic              nxt_valid;

    pwm_prescaler #(
        .DIV_WL(DIV_WL)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .div  (div),
        .tick (tick)
    );

    assign duty     = PWM_WL'(to_offset_bin(s_data, PWM_WL));
    assign s_ready  = en & ~nxt_valid;
    assign accept   = s_valid & s_ready;
    assign boundary = tick & (cnt == '1);

    // Period counter: advances one step per prescaler tick, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + PWM_WL'(1);
        end
    end

    // Registered comparator output and period-start pulse (aligned to cnt==0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else if (!en) begin
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= (cnt < act_duty);
            period_start <= boundary;
        end
    end

    // Sample buffer: one pending duty, promoted to active only at a boundary.
    // With nothing pending, a sample arriving on the boundary cycle is applied
    // directly so it is not delayed by a whole period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_duty  <= DUTY_MID;
            nxt_duty  <= '0;
            nxt_valid <= 1'b0;
        end else if (!en) begin
            nxt_valid <= 1'b0;
        end else if (boundary) begin
            if (nxt_valid) begin
                act_duty  <= nxt_duty;
                nxt_valid <= 1'b0;
            end else if (accept) begin
                act_duty <= duty;
            end
        end else if (accept) begin
            nxt_duty  <= duty;
            nxt_valid <= 1'b1;
        end
    end

    // Sticky underrun: a boundary with no fresh sample wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else if (boundary & ~nxt_valid & ~accept) begin
            underrun <= 1'b1;
        end else if (clr_underrun) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_dac_out.sv
// Self-checking bench for pwm_dac_out: directed scenarios plus randomized
// traffic, all compared against a timing/arithmetic reference model.
module tb_pwm_dac_out;

    localparam int PER = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  div = 8'd0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = 16'd0;
    logic        s_ready;
    logic        clr_underrun = 1'b0;
    logic        pwm_out;
    logic        period_start;
    logic        underrun;

    pwm_dac_out dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .div         (div),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .clr_underrun(clr_underrun),
        .pwm_out     (pwm_out),
        .period_start(period_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    int m_c;      // enabled clk edges since enable
    bit m_pend;
    int m_nxt;
    int m_act;
    bit m_und;
    bit m_pwm;
    bit m_ps;

    // source state
    logic [15:0] src_q[$];
    bit          src_valid;
    logic [15:0] src_data;
    bit          en_cur;

    // observed PWM windows, one per completed period
    int obs_highs, obs_len;
    int win_highs[$];
    int win_len[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int to_duty(input logic [15:0] x);
        return (int'($signed(x)) + 32768) / 256;
    endfunction

    function automatic logic [15:0] rand_sample();
        logic [15:0] corners [6];
        corners = '{16'h8000, 16'h7FFF, 16'h0000, 16'h4000, 16'h00FF, 16'hFF80};
        if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
        return 16'($urandom);
    endfunction

    task automatic model_reset();
        m_c = 0; m_pend = 0; m_nxt = 0; m_act = PER / 2;
        m_und = 0; m_pwm = 0; m_ps = 0;
    endtask

    task automatic clear_win();
        obs_highs = 0; obs_len = 0;
        win_highs.delete(); win_len.delete();
    endtask

    // One clock: drive at negedge, predict, then compare after the next negedge.
    task automatic cycle(input bit n_en, input bit n_valid, input logic [15:0] n_data,
                         input bit n_clr, output bit acc);
        int d, cnt;
        bit tick, bnd, set_u;
        en = n_en; s_valid = n_valid; s_data = n_data; clr_underrun = n_clr;
        #1;
        check("s_ready", s_ready, {31'd0, n_en && !m_pend});
        acc = 0;
        d = int'(div) + 1;
        if (!n_en) begin
            m_c = 0; m_pend = 0; m_pwm = 0; m_ps = 0;
        end else begin
            cnt   = (m_c / d) % PER;
            tick  = (m_c % d) == d - 1;
            bnd   = tick && cnt == PER - 1;
            acc   = n_valid && !m_pend;
            m_pwm = cnt < m_act;
            m_ps  = bnd;
            set_u = bnd && !m_pend && !acc;
            if (bnd) begin
                if (m_pend) begin m_act = m_nxt; m_pend = 0; end
                else if (acc) m_act = to_duty(n_data);
            end else if (acc) begin
                m_nxt = to_duty(n_data); m_pend = 1;
            end
            if (set_u) m_und = 1;
            else if (n_clr) m_und = 0;
            m_c++;
        end
        @(negedge clk);
        check("pwm_out", pwm_out, {31'd0, m_pwm});
        check("period_start", period_start, {31'd0, m_ps});
        check("underrun", underrun, {31'd0, m_und});
        obs_highs += int'(pwm_out);
        obs_len++;
        if (period_start === 1'b1) begin
            win_highs.push_back(obs_highs);
            win_len.push_back(obs_len);
            obs_highs = 0; obs_len = 0;
        end
    endtask

    task automatic run(input int n, input int p_push, input int p_clr, input int p_en_tog);
        bit acc, clr;
        for (int i = 0; i < n; i++) begin
            if (p_push > 0 && $urandom_range(99) < p_push && src_q.size() < 4)
                src_q.push_back(rand_sample());
            if (p_en_tog > 0 && $urandom_range(999) < p_en_tog) en_cur = !en_cur;
            if (!src_valid && src_q.size() > 0) begin
                src_valid = 1; src_data = src_q.pop_front();
            end
            clr = en_cur && p_clr > 0 && $urandom_range(99) < p_clr;
            cycle(en_cur, src_valid, src_data, clr, acc);
            if (acc) src_valid = 0;
        end
    endtask

    // Asynchronous reset pulse asserted between edges; outputs must clear at once.
    task automatic rst_pulse();
        rst_n = 1'b0;
        src_q.delete(); src_valid = 0; s_valid = 1'b0; clr_underrun = 1'b0;
        #1;
        check("rst_pwm_out", pwm_out, 0);
        check("rst_period_start", period_start, 0);
        check("rst_underrun", underrun, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start(input int div_v);
        rst_pulse();
        div = 8'(div_v);
        en_cur = 1;
        clear_win();
    endtask

    task automatic check_win(input string tag, input int idx, input int exp_h, input int exp_l);
        if (idx >= win_highs.size()) begin
            check({tag, "_missing"}, win_highs.size(), idx + 1);
        end else begin
            check({tag, "_highs"}, win_highs[idx], exp_h);
            check({tag, "_len"}, win_len[idx], exp_l);
        end
    endtask

    initial begin
        int p_choice [4];
        p_choice = '{0, 1, 2, 50};
        model_reset();
        clear_win();
        en_cur = 0; src_valid = 0; src_data = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_pwm_out", pwm_out, 0);
        check("reset_period_start", period_start, 0);
        check("reset_underrun", underrun, 0);
        check("reset_s_ready", s_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // midscale samples, div=0: 128 of 256 high, period every 256 clks
        start(0);
        for (int i = 0; i < 8; i++) src_q.push_back(16'h0000);
        run(3 * PER, 0, 0, 0);
        check_win("A_w0", 0, 128, 256);
        check_win("A_w1", 1, 128, 256);
        check_win("A_w2", 2, 128, 256);

        // full-scale negative then positive; second sample waits for the swap
        start(0);
        src_q.push_back(16'h8000); src_q.push_back(16'h7FFF);
        src_q.push_back(16'h0000); src_q.push_back(16'h0000);
        run(3 * PER, 0, 0, 0);
        check_win("B_w1", 1, 0, 256);
        check_win("B_w2", 2, 255, 256);
        check("B_underrun", underrun, 0);

        // div=3, single sample then starvation, then clear
        start(3);
        src_q.push_back(16'h4000);
        run(3 * 4 * PER, 0, 0, 0);
        check_win("C_w0", 0, 512, 1024);
        check_win("C_w1", 1, 768, 1024);
        check_win("C_w2", 2, 768, 1024);
        check("C_underrun_set", underrun, 1);
        run(1, 0, 100, 0);
        check("C_underrun_clr", underrun, 0);

        // sample offered exactly on the boundary cycle with an empty buffer
        start(0);
        run(PER - 1, 0, 0, 0);
        src_q.push_back(16'h7FFF);
        run(1, 0, 0, 0);
        check("D_underrun", underrun, 0);
        run(PER, 0, 0, 0);
        check_win("D_w0", 0, 128, 256);
        check_win("D_w1", 1, 255, 256);

        // enable drop, re-enable and reset mid-period
        start(0);
        src_q.push_back(16'h4000);
        run(300, 0, 0, 0);
        en_cur = 0;
        run(1, 0, 0, 0);
        check("F_pwm_en_low", pwm_out, 0);
        run(20, 0, 0, 0);
        en_cur = 1;
        clear_win();
        run(PER + 10, 0, 0, 0);
        check_win("F_reen_w0", 0, 192, 256);
        check("F_underrun_set", underrun, 1);
        run(40, 0, 0, 0);
        rst_pulse();
        en_cur = 1;
        clear_win();
        run(PER, 0, 0, 0);
        check_win("F_rst_w0", 0, 128, 256);

        // randomized traffic
        for (int seg = 0; seg < 10; seg++) begin
            start($urandom_range(3));
            run(1500, p_choice[$urandom_range(3)], 1, 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
